// File: rtl/calc_pkg.sv
// Shared calculator types: keypad geometry, key codes and the scanner FSM states.
package calc_pkg;

  localparam int unsigned NumKeyRows = 4;
  localparam int unsigned NumKeyCols = 4;
  localparam int unsigned KeyCodeW   = $clog2(NumKeyRows * NumKeyCols);

  typedef logic [KeyCodeW-1:0] keycode_t;

  typedef enum logic [3:0] {
    KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7,
    KEY_8, KEY_9, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_EQ, KEY_CLR
  } key_t;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } scan_state_e;

  // Front-panel legend: 7 8 9 / | 4 5 6 * | 1 2 3 - | C 0 = +
  function automatic key_t keycode2key(keycode_t code);
    key_t k;
    k = KEY_CLR;
    case (code)
      keycode_t'(0):  k = KEY_7;
      keycode_t'(1):  k = KEY_8;
      keycode_t'(2):  k = KEY_9;
      keycode_t'(3):  k = KEY_DIV;
      keycode_t'(4):  k = KEY_4;
      keycode_t'(5):  k = KEY_5;
      keycode_t'(6):  k = KEY_6;
      keycode_t'(7):  k = KEY_MUL;
      keycode_t'(8):  k = KEY_1;
      keycode_t'(9):  k = KEY_2;
      keycode_t'(10): k = KEY_3;
      keycode_t'(11): k = KEY_SUB;
      keycode_t'(12): k = KEY_CLR;
      keycode_t'(13): k = KEY_0;
      keycode_t'(14): k = KEY_EQ;
      keycode_t'(15): k = KEY_ADD;
      default:        k = KEY_CLR;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the pulled-up row returns; resets to all ones (no key).
module keypad_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      q_o    <= '1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: rotating one-cold column strobe, debounced press/release,
// one key event per press on a valid/ready handshake with a sticky overflow flag.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned NumRows       = NumKeyRows,
  parameter int unsigned NumCols       = NumKeyCols,
  parameter int unsigned ScanDivider   = 1000,
  parameter int unsigned DebounceCount = 50000,
  localparam int unsigned CodeW = (NumRows * NumCols > 1) ? $clog2(NumRows * NumCols) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumRows-1:0] rows_i,
  output logic [NumCols-1:0] cols_o,
  output logic               key_valid_o,
  output logic [CodeW-1:0]   key_code_o,
  input  logic               key_ready_i,
  output logic               overflow_o
);

  localparam int unsigned RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned ColW  = (NumCols > 1) ? $clog2(NumCols) : 1;
  localparam int unsigned SlotW = (ScanDivider > 1) ? $clog2(ScanDivider) : 1;
  localparam int unsigned DebW  = (DebounceCount > 1) ? $clog2(DebounceCount) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(ScanDivider - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCount - 1);
  localparam logic [ColW-1:0]  ColLast  = ColW'(NumCols - 1);

  logic [NumRows-1:0] rows_s;

  scan_state_e        state_q, state_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic [DebW-1:0]    deb_q, deb_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [NumRows-1:0] pat_q, pat_d;
  logic [NumCols-1:0] cols_q, cols_d;
  logic               valid_q, valid_d;
  logic [CodeW-1:0]   code_q, code_d;
  logic               ovf_q, ovf_d;

  logic               emit;
  logic               rows_idle;
  int unsigned        n_low;
  logic [RowW-1:0]    row_hit;

  keypad_sync #(
    .Width(NumRows)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rows_i),
    .q_o   (rows_s)
  );

  // Count low rows and remember which one; only a single low row is a valid key.
  always_comb begin
    n_low   = 0;
    row_hit = '0;
    for (int i = 0; i < int'(NumRows); i++) begin
      if (!rows_s[i]) begin
        n_low   = n_low + 1;
        row_hit = RowW'(i);
      end
    end
  end

  assign rows_idle = (rows_s == '1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    deb_d   = deb_q;
    col_d   = col_q;
    row_d   = row_q;
    pat_d   = pat_q;
    cols_d  = cols_q;
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    emit    = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (slot_q == SlotLast) begin
          slot_d = '0;
          if (!rows_idle && (n_low == 1)) begin
            row_d   = row_hit;
            pat_d   = rows_s;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            // Idle or ghosted sample: move the strobe to the next column.
            cols_d = {cols_q[NumCols-2:0], cols_q[NumCols-1]};
            col_d  = (col_q == ColLast) ? '0 : col_q + ColW'(1);
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (rows_s == pat_q) begin
          if (deb_q == DebLast) begin
            state_d = ST_PRESSED;
            emit    = 1'b1;
          end else begin
            deb_d = deb_q + DebW'(1);
          end
        end else begin
          state_d = ST_SCAN;
          slot_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (rows_idle) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rows_idle) begin
          if (deb_q == DebLast) begin
            state_d = ST_SCAN;
            slot_d  = '0;
          end else begin
            deb_d = deb_q + DebW'(1);
          end
        end else begin
          state_d = ST_PRESSED;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    // Handshake: an accepted event drops valid unless a new one lands on the same edge.
    if (valid_q && key_ready_i) begin
      valid_d = 1'b0;
    end
    if (emit) begin
      if (!valid_q || key_ready_i) begin
        valid_d = 1'b1;
        code_d  = CodeW'(32'(row_q) * NumCols + 32'(col_q));
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SCAN;
      slot_q  <= '0;
      deb_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pat_q   <= '1;
      cols_q  <= {{(NumCols-1){1'b1}}, 1'b0};
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      deb_q   <= deb_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      cols_q  <= cols_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cols_o      = cols_q;
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;
  assign overflow_o  = ovf_q;

endmodule
